div_unit: RTL

Iterative radix-2 restoring divider in the EX stage. It consumes the operand and opcode fields that the ID/EX pipeline register delivers and serves MIPS DIV/DIVU. It holds the pipeline via its handshake: EX control keeps `start_i` high and stalls upstream stages until `ready_o` asserts. It then forwards the 64-bit {remainder, quotient} toward the HI/LO write path.

---
 rtl/div_unit_if.sv | 22 ++
 rtl/div_unit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/div_unit_if.sv
// Operand/result bundle between EX control (master) and the iterative divider (slave).
interface div_unit_if #(
    parameter int WIDTH = 32
) ();
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: ready WIDTH+2 edges after accept (2 for /0), holds until start_i drops.
// Signed path only when DIV_SIGNED_EN is defined; otherwise every operation is unsigned.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH:0]     work_q, work_d;
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic [WIDTH-1:0]     dvnd_abs, dvsr_abs, quo_fix, rem_fix;
    logic [2*WIDTH:0]     shifted;
    logic [WIDTH+1:0]     trial;

`ifdef DIV_SIGNED_EN
    logic                 quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;

    assign dvnd_abs = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
    assign dvsr_abs = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;
    assign quo_fix  = quo_neg_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    assign rem_fix  = rem_neg_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
`else
    logic                 unused_signed;

    assign unused_signed = bus.signed_div_i;
    assign dvnd_abs = bus.opdata1_i;
    assign dvsr_abs = bus.opdata2_i;
    assign quo_fix  = work_q[WIDTH-1:0];
    assign rem_fix  = work_q[2*WIDTH-1:WIDTH];
`endif

    // Partial remainder lives in the upper W+1 bits, quotient bits shift in at the bottom.
    assign shifted = work_q << 1;
    assign trial   = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, dvsr_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        dvsr_d   = dvsr_q;
        result_d = result_q;
        ready_d  = ready_q;
`ifdef DIV_SIGNED_EN
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
`endif
        case (state_q)
            FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (bus.start_i && !bus.annul_i) begin
                    dvsr_d = dvsr_abs;
                    work_d = {{(WIDTH+1){1'b0}}, dvnd_abs};
`ifdef DIV_SIGNED_EN
                    quo_neg_d = bus.signed_div_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                    rem_neg_d = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
`endif
                    if (bus.opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d = ON;
                        cnt_d   = '0;
                    end
                end
            end
            BYZERO: begin
                result_d = '0;
                state_d  = END;
            end
            ON: begin
                if (bus.annul_i) begin
                    state_d = FREE;
                end else if (cnt_q < CW'(WIDTH)) begin
                    work_d = shifted;
                    if (!trial[WIDTH+1]) begin
                        work_d[2*WIDTH:WIDTH] = trial[WIDTH:0];
                        work_d[0]             = 1'b1;
                    end
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    result_d = {rem_fix, quo_fix};
                    state_d  = END;
                end
            end
            END: begin
                if (!bus.start_i) begin
                    state_d  = FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else begin
                    ready_d = 1'b1;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FREE;
            cnt_q    <= '0;
            work_q   <= '0;
            dvsr_q   <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            dvsr_q   <= dvsr_d;
            result_q <= result_d;
            ready_q  <= ready_d;
`ifdef DIV_SIGNED_EN
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
`endif
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
endmodule
